// File: rtl/dmx_tx_if.sv
// dmx_tx_if: bit tick, frame request, channel fetch and line signals of dmx_tx.
// DMX_ALT_START_CODE_EN adds the start_code input.
interface dmx_tx_if;
    logic       en;
    logic       start;
    logic [8:0] ch_addr;
    logic [7:0] ch_data;
    logic       tx;
    logic       busy;
    logic       done;
`ifdef DMX_ALT_START_CODE_EN
    logic [7:0] start_code;

    modport master (
        output en, start, ch_data, start_code,
        input  ch_addr, tx, busy, done
    );
    modport slave (
        input  en, start, ch_data, start_code,
        output ch_addr, tx, busy, done
    );
`else
    modport master (
        output en, start, ch_data,
        input  ch_addr, tx, busy, done
    );
    modport slave (
        input  en, start, ch_data,
        output ch_addr, tx, busy, done
    );
`endif
endinterface

// File: rtl/dmx_tx.sv
// dmx_tx: DMX512 frame transmitter (break, MAB, start code, NUM_CH slots).
// Optional DMX_ALT_START_CODE_EN: programmable slot-0 start code.
module dmx_tx #(
    parameter int NUM_CH     = 512,
    parameter int BREAK_BITS = 25,
    parameter int MAB_BITS   = 3,
    parameter int STOP_BITS  = 2
) (
    input logic     int_osc,
    input logic     reset,
    dmx_tx_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        BREAK,
        MAB,
        START_BIT,
        DATA,
        STOP
    } state_e;

    localparam logic [9:0] LastSlot = 10'(NUM_CH);
    localparam logic [4:0] BrkEnd   = 5'(BREAK_BITS - 1);
    localparam logic [4:0] MabEnd   = 5'(MAB_BITS - 1);
    localparam logic [4:0] StopEnd  = 5'(STOP_BITS - 1);

    state_e     state_q;
    logic       pending_q;
    logic       busy_q;
    logic       done_q;
    logic       tx_q;
    logic [8:0] addr_q;
    logic [7:0] shift_q;
    logic [3:0] bit_q;
    logic [4:0] tick_q;
    logic [9:0] slot_q;
    logic [7:0] code;
    logic [7:0] load_d;

`ifdef DMX_ALT_START_CODE_EN
    logic [7:0] code_q;
    assign code = code_q;
`else
    assign code = 8'h00;
`endif

    // slot 0 carries the start code, later slots the fetched channel byte
    assign load_d = (slot_q == '0) ? code : bus.ch_data;

    always_ff @(posedge int_osc) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= 1'b1;
            addr_q    <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            tick_q    <= '0;
            slot_q    <= '0;
`ifdef DMX_ALT_START_CODE_EN
            code_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE && !busy_q && bus.start) begin
                pending_q <= 1'b1;
                busy_q    <= 1'b1;
`ifdef DMX_ALT_START_CODE_EN
                code_q    <= bus.start_code;
`endif
            end
            if (bus.en) begin
                unique case (state_q)
                    IDLE: begin
                        if (pending_q) begin
                            pending_q <= 1'b0;
                            state_q   <= BREAK;
                            tx_q      <= 1'b0;
                            tick_q    <= '0;
                        end
                    end
                    BREAK: begin
                        if (tick_q == BrkEnd) begin
                            state_q <= MAB;
                            tx_q    <= 1'b1;
                            tick_q  <= '0;
                        end else begin
                            tick_q <= tick_q + 5'd1;
                        end
                    end
                    MAB: begin
                        if (tick_q == MabEnd) begin
                            state_q <= START_BIT;
                            tx_q    <= 1'b0;
                            slot_q  <= '0;
                        end else begin
                            tick_q <= tick_q + 5'd1;
                        end
                    end
                    START_BIT: begin
                        state_q <= DATA;
                        tx_q    <= load_d[0];
                        shift_q <= {1'b0, load_d[7:1]};
                        bit_q   <= '0;
                    end
                    DATA: begin
                        if (bit_q == 4'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            tick_q  <= '0;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 4'd1;
                        end
                    end
                    STOP: begin
                        if (tick_q != StopEnd) begin
                            tick_q <= tick_q + 5'd1;
                        end else if (slot_q == LastSlot) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // fetch the next slot's byte one bit time ahead
                            state_q <= START_BIT;
                            tx_q    <= 1'b0;
                            addr_q  <= slot_q[8:0];
                            slot_q  <= slot_q + 10'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ch_addr = addr_q;
endmodule

// File: tb/tb_dmx_tx.sv
// tb_dmx_tx: randomized directed bench for dmx_tx (NUM_CH=4, en every
// 10 cycles) against a tick-level frame model built from the DMX rules.
module tb_dmx_tx;
    localparam int N    = 4;
    localparam int BRK  = 25;
    localparam int MAB  = 3;
    localparam int SLOT = 11;
    localparam int HDR  = BRK + MAB;
    localparam int FLEN = HDR + (N + 1) * SLOT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dmx_tx_if bus ();

    dmx_tx #(
        .NUM_CH    (N),
        .BREAK_BITS(BRK),
        .MAB_BITS  (MAB),
        .STOP_BITS (2)
    ) dut (
        .int_osc(clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [N];
    int div   = 0;
    int div_n = 10;
    int en_count = 0;

    bit         mbusy;
    bit         armed;
    bit         in_frame;
    bit         exp_done;
    int         ftick;
    int         maddr;
    int         brk_en;
    int         frames_done = 0;
    logic [7:0] mcode = 8'h00;
    logic       fbits [FLEN];

    int   done_cnt   = 0;
    int   busy_falls = 0;
    logic busy_prev  = 1'b0;
    int   tx_bad     = 0;
    int   busy_bad   = 0;
    int   done_bad   = 0;
    int   addr_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] slot_val(input int s);
        if (s == 0) return mcode;
        return mem[s - 1];
    endfunction

    function automatic logic exp_bit(input int f);
        int s;
        int r;
        logic [7:0] b;
        if (f < BRK) return 1'b0;
        if (f < HDR) return 1'b1;
        s = (f - HDR) / SLOT;
        r = (f - HDR) % SLOT;
        b = slot_val(s);
        if (r == 0) return 1'b0;
        if (r <= 8) return b[r - 1];
        return 1'b1;
    endfunction

    task automatic decode_frame();
        int z = 0;
        int o = 0;
        int base;
        logic [7:0] b;
        while (z < FLEN && fbits[z] === 1'b0) z++;
        while (z + o < FLEN && fbits[z + o] === 1'b1) o++;
        chk("break_len", z, BRK);
        chk("mab_len", o, MAB);
        for (int s = 0; s <= N; s++) begin
            base = HDR + s * SLOT;
            for (int k = 0; k < 8; k++) b[k] = fbits[base + 1 + k];
            chk($sformatf("slot%0d_start", s), fbits[base], 0);
            chk($sformatf("slot%0d_byte", s), b, slot_val(s));
            chk($sformatf("slot%0d_stop", s),
                {fbits[base + 9], fbits[base + 10]}, 2'b11);
        end
    endtask

    task automatic cyc();
        logic       en_now;
        logic       st_now;
        logic       rst_now;
        logic [7:0] code_now;
        bit         pre_busy;
        logic       exp_tx;
        bit         valid;
        en_now = (div == 0);
        div = (div + 1) % div_n;
        bus.en = en_now;
        st_now = bus.start;
        rst_now = rst_n;
`ifdef DMX_ALT_START_CODE_EN
        code_now = bus.start_code;
`else
        code_now = 8'h00;
`endif
        @(posedge clk);
        #1;
        if (en_now) en_count++;
        exp_done = 0;
        if (!rst_now) begin
            mbusy = 0;
            armed = 0;
            in_frame = 0;
            maddr = 0;
        end else begin
            pre_busy = mbusy;
            if (en_now) begin
                if (in_frame) begin
                    ftick++;
                    if (ftick == FLEN) begin
                        in_frame = 0;
                        mbusy = 0;
                        exp_done = 1;
                        frames_done++;
                        decode_frame();
                    end else if (ftick >= HDR + SLOT &&
                                 (ftick - HDR) % SLOT == 0) begin
                        maddr = (ftick - HDR) / SLOT - 1;
                    end
                end else if (armed) begin
                    armed = 0;
                    in_frame = 1;
                    ftick = 0;
                    brk_en = en_count;
                end
            end
            if (st_now && !pre_busy) begin
                armed = 1;
                mbusy = 1;
                mcode = code_now;
            end
        end
        exp_tx = in_frame ? exp_bit(ftick) : 1'b1;
        if (in_frame) fbits[ftick] = bus.tx;
        if (bus.tx !== exp_tx) tx_bad++;
        if (bus.busy !== mbusy) busy_bad++;
        if (bus.done !== exp_done) done_bad++;
        if (bus.ch_addr !== 9'(maddr)) addr_bad++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            chk("done_span", en_count - brk_en, FLEN);
        end
        if (busy_prev === 1'b1 && bus.busy === 1'b0) busy_falls++;
        busy_prev = bus.busy;
        // ch_data only has to hold from an address step to its capture
        valid = in_frame && ftick >= HDR + SLOT && (ftick - HDR) % SLOT == 0;
        bus.ch_data = valid ? mem[int'(bus.ch_addr) % N] : 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse_start(input int len);
        bus.start = 1'b1;
        repeat (len) cyc();
        bus.start = 1'b0;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((mbusy || armed) && n < max) begin
            cyc();
            n++;
        end
        chk("frame_timeout", n < max, 1);
    endtask

    task automatic run_to_tick(input int t, input int max);
        int n = 0;
        while (!(in_frame && ftick >= t) && n < max) begin
            cyc();
            n++;
        end
        chk("tick_timeout", n < max, 1);
    endtask

    task automatic flush(input string ph);
        chk({ph, "_tx_wave"}, tx_bad, 0);
        chk({ph, "_busy"}, busy_bad, 0);
        chk({ph, "_done"}, done_bad, 0);
        chk({ph, "_addr"}, addr_bad, 0);
        tx_bad = 0;
        busy_bad = 0;
        done_bad = 0;
        addr_bad = 0;
    endtask

    initial begin
        int low;
        int n;
        int target;
        bus.en = 1'b0;
        bus.start = 1'b0;
        bus.ch_data = 8'h00;
`ifdef DMX_ALT_START_CODE_EN
        bus.start_code = 8'h00;
`endif
        mem = '{8'h01, 8'h80, 8'hFF, 8'h5A};

        div_n = 2;
        repeat (5) begin
            cyc();
            chk("rst_tx", bus.tx, 1);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_addr", bus.ch_addr, 0);
        end
        rst_n = 1'b1;
        div_n = 10;
        div = 0;
        idle(40);
        flush("idle");

        done_cnt = 0;
        busy_falls = 0;
        idle($urandom_range(0, 9));
        pulse_start(1);
        run_to_tick(HDR + SLOT + 5, 2000);
        pulse_start(1);
        run_idle(2000);
        idle(30);
        chk("short_done_cnt", done_cnt, 1);
        chk("short_busy_falls", busy_falls, 1);
        flush("short");

        for (int f = 0; f < 3; f++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
`ifdef DMX_ALT_START_CODE_EN
            bus.start_code = 8'($urandom);
`endif
            if (f == 1) begin
                while (div != 0) cyc();
            end else begin
                idle($urandom_range(1, 15));
            end
            pulse_start($urandom_range(1, 3));
            run_idle(2000);
            idle(5);
        end
        chk("rand_done_cnt", done_cnt, 4);
        flush("rand");

        done_cnt = 0;
        pulse_start(1);
        run_to_tick(HDR + 2 * SLOT + 4, 2000);
        idle(3);
        rst_n = 1'b0;
        cyc();
        chk("abort_tx", bus.tx, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_addr", bus.ch_addr, 0);
        rst_n = 1'b1;
        idle(50);
        chk("abort_no_done", done_cnt, 0);
        foreach (mem[i]) mem[i] = 8'($urandom);
        pulse_start(1);
        run_idle(2000);
        idle(5);
        chk("after_abort_done", done_cnt, 1);
        flush("abort");

        done_cnt = 0;
`ifdef DMX_ALT_START_CODE_EN
        bus.start_code = 8'hCC;
`endif
        bus.start = 1'b1;
        cyc();
        low = 0;
        n = 0;
        target = frames_done + 3;
        while (frames_done < target && n < 5000) begin
            cyc();
            n++;
            if (bus.busy === 1'b0) low++;
        end
        bus.start = 1'b0;
        chk("b2b_timeout", n < 5000, 1);
        chk("b2b_busy_low", low, 3);
        chk("b2b_done_cnt", done_cnt, 3);
        run_idle(2000);
        idle(20);
        flush("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
